// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: bus width defaults, FSM encoding, latency.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package periph_bus_pkg;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;

    // Request cycle through done pulse, counted inclusively: IDLE, ISSUE, RESP, DONE.
    localparam int LAT_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_arbiter.sv
// Combinational round-robin select: first requester after the pointer wins, wrapping around.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the selection.
module rr_arbiter
    import periph_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    int cand;

    // Scan pointer+1 .. pointer+N modulo N; the last winner is visited last.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(pointer) + i) % N;
            if (!any && req[cand[IW-1:0]]) begin
                any                  = 1'b1;
                grant[cand[IW-1:0]]  = 1'b1;
                index                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares one peripheral bus among N_MASTERS requesters; one strobe cycle then one response cycle.
// Latency: done pulse in the 4th cycle counting the request cycle; one transaction per 4 cycles.
// Backpressure: requesters hold req until m_gnt; optional ARB_FIXED_PRIO0_EN gives master 0 priority.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS-1:0]    m_we,
    input  logic [N_MASTERS*AW-1:0] m_addr,
    input  logic [N_MASTERS*DW-1:0] m_wdata,
    output logic [N_MASTERS-1:0]    m_gnt,
    output logic [N_MASTERS-1:0]    m_done,
    output logic [DW-1:0]           m_rdata,
    output logic [AW-1:0]           sys_w_addr,
    output logic [AW-1:0]           sys_r_addr,
    output logic [DW-1:0]           sys_w_line,
    input  logic [DW-1:0]           sys_r_line,
    output logic                    sys_w,
    output logic                    sys_r
);

    localparam int            IW      = idx_w(N_MASTERS);
    localparam logic [IW-1:0] PTR_RST = IW'(N_MASTERS - 1);

    arb_state_t state, state_nxt;

    logic [IW-1:0]        rr_ptr;
    logic                 lat_we;
    logic                 capture;

    logic [AW-1:0]        addr_arr  [N_MASTERS];
    logic [DW-1:0]        wdata_arr [N_MASTERS];

    logic [N_MASTERS-1:0] rr_req;
    logic [N_MASTERS-1:0] rr_gnt;
    logic [IW-1:0]        rr_idx;
    logic                 rr_any;

    logic [N_MASTERS-1:0] sel_gnt;
    logic [IW-1:0]        sel_idx;
    logic                 sel_any;
    logic                 ptr_upd;

    logic [N_MASTERS-1:0] gnt_nxt;
    logic [N_MASTERS-1:0] done_nxt;
    logic [DW-1:0]        rdata_nxt;
    logic                 sys_w_nxt;
    logic                 sys_r_nxt;
    logic [AW-1:0]        addr_nxt;
    logic [DW-1:0]        line_nxt;
    logic [AW-1:0]        bus_addr;

    // Unpack the flat per-master address and data buses.
    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            addr_arr[k]  = m_addr[k*AW +: AW];
            wdata_arr[k] = m_wdata[k*DW +: DW];
        end
    end

    rr_arbiter #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_rr (
        .req     (rr_req),
        .pointer (rr_ptr),
        .grant   (rr_gnt),
        .index   (rr_idx),
        .any     (rr_any)
    );

`ifdef ARB_FIXED_PRIO0_EN
    // Master 0 is taken out of the rotation; the others share the round-robin pointer.
    assign rr_req = {m_req[N_MASTERS-1:1], 1'b0};

    // Master 0 pre-empts the rotation and leaves the pointer where it was.
    always_comb begin
        sel_gnt = rr_gnt;
        sel_idx = rr_idx;
        sel_any = rr_any;
        ptr_upd = 1'b1;
        if (m_req[0]) begin
            sel_gnt    = '0;
            sel_gnt[0] = 1'b1;
            sel_idx    = '0;
            sel_any    = 1'b1;
            ptr_upd    = 1'b0;
        end
    end
`else
    assign rr_req  = m_req;
    assign sel_gnt = rr_gnt;
    assign sel_idx = rr_idx;
    assign sel_any = rr_any;
    assign ptr_upd = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next output values; bus fields return to zero outside the strobe cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        gnt_nxt   = m_gnt;
        done_nxt  = '0;
        rdata_nxt = m_rdata;
        sys_w_nxt = 1'b0;
        sys_r_nxt = 1'b0;
        addr_nxt  = '0;
        line_nxt  = '0;
        case (state)
            ST_IDLE: begin
                gnt_nxt = '0;
                if (sel_any) begin
                    capture   = 1'b1;
                    state_nxt = ST_ISSUE;
                    gnt_nxt   = sel_gnt;
                    sys_w_nxt = m_we[sel_idx];
                    sys_r_nxt = !m_we[sel_idx];
                    addr_nxt  = addr_arr[sel_idx];
                    line_nxt  = m_we[sel_idx] ? wdata_arr[sel_idx] : '0;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Peripherals drive read data only in this cycle; capture it at its closing edge.
                state_nxt = ST_DONE;
                done_nxt  = m_gnt;
                if (!lat_we) begin
                    rdata_nxt = sys_r_line;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Grant-time capture: direction for the response phase and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we <= 1'b0;
            rr_ptr <= PTR_RST;
        end else if (capture) begin
            lat_we <= m_we[sel_idx];
            if (ptr_upd) begin
                rr_ptr <= sel_idx;
            end
        end
    end

    // Registered master-side and bus-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gnt      <= '0;
            m_done     <= '0;
            m_rdata    <= '0;
            sys_w      <= 1'b0;
            sys_r      <= 1'b0;
            bus_addr   <= '0;
            sys_w_line <= '0;
        end else begin
            m_gnt      <= gnt_nxt;
            m_done     <= done_nxt;
            m_rdata    <= rdata_nxt;
            sys_w      <= sys_w_nxt;
            sys_r      <= sys_r_nxt;
            bus_addr   <= addr_nxt;
            sys_w_line <= line_nxt;
        end
    end

    assign sys_w_addr = bus_addr;
    assign sys_r_addr = bus_addr;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed vector table, corner sequences, random traffic.
// A transaction-level model (phase counter per transaction) predicts every output each cycle.
// Masters obey the request/hold/drop rules; the peripheral drives read data the cycle after sys_r.
module tb_periph_bus_arbiter;
    import periph_bus_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_req, m_we, m_gnt, m_done;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, sys_w_line, sys_r_line;
    logic [AW-1:0]   sys_w_addr, sys_r_addr;
    logic            sys_w, sys_r;

    logic [AW-1:0]   b_addr  [N];
    logic [DW-1:0]   b_wdata [N];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW]  = b_addr[k];
            m_wdata[k*DW +: DW] = b_wdata[k];
        end
    end

    periph_bus_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_gnt      (m_gnt),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .sys_w_addr (sys_w_addr),
        .sys_r_addr (sys_r_addr),
        .sys_w_line (sys_w_line),
        .sys_r_line (sys_r_line),
        .sys_w      (sys_w),
        .sys_r      (sys_r)
    );

    // ---------------- reference model ----------------
    // phase: 0 = no transaction, 1..3 = cycles since the grant edge.
    int            mp_phase, mp_ptr, mp_m;
    logic          mp_we;
    logic [AW-1:0] mp_addr;
    logic [DW-1:0] mp_wdata, mp_rdata;

    function automatic void model_reset();
        mp_phase = 0;
        mp_ptr   = N - 1;
        mp_m     = 0;
        mp_we    = 1'b0;
        mp_addr  = '0;
        mp_wdata = '0;
        mp_rdata = '0;
    endfunction

    function automatic int model_pick();
        int w;
        w = -1;
`ifdef ARB_FIXED_PRIO0_EN
        if (m_req[0]) return 0;
`endif
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (mp_ptr + i) % N;
`ifdef ARB_FIXED_PRIO0_EN
            if (c == 0) continue;
`endif
            if (w < 0 && m_req[c]) w = c;
        end
        return w;
    endfunction

    // Advance the model across one posedge using the inputs present before it.
    function automatic void model_step();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        if (mp_phase == 0) begin
            if (m_req != '0) begin
                w        = model_pick();
                mp_m     = w;
                mp_we    = m_we[w];
                mp_addr  = b_addr[w];
                mp_wdata = b_wdata[w];
`ifdef ARB_FIXED_PRIO0_EN
                if (w != 0) mp_ptr = w;
`else
                mp_ptr = w;
`endif
                mp_phase = 1;
            end
        end else begin
            if (mp_phase == 2 && !mp_we) mp_rdata = sys_r_line;
            mp_phase = (mp_phase + 1) % LAT_CYCLES;
        end
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_outputs();
        logic [N-1:0] eg;
        eg = '0;
        if (mp_phase != 0) eg[mp_m] = 1'b1;
        chk("gnt",    64'(m_gnt),   64'(eg));
        chk("done",   64'(m_done),  64'((mp_phase == 3) ? eg : '0));
        chk("rdata",  64'(m_rdata), 64'(mp_rdata));
        chk("sys_w",  64'(sys_w),   64'(mp_phase == 1 && mp_we));
        chk("sys_r",  64'(sys_r),   64'(mp_phase == 1 && !mp_we));
        chk("w_addr", 64'(sys_w_addr), 64'((mp_phase == 1) ? mp_addr : '0));
        chk("r_addr", 64'(sys_r_addr), 64'((mp_phase == 1) ? mp_addr : '0));
        chk("w_line", 64'(sys_w_line), 64'((mp_phase == 1 && mp_we) ? mp_wdata : '0));
    endfunction

    // ---------------- cycle driver with peripheral ----------------
    logic          r_pending = 1'b0;
    logic [DW-1:0] periph_val = '0;

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        // Peripheral drives read data only in the cycle after a read strobe; junk otherwise.
        sys_r_line = r_pending ? periph_val : DW'($urandom);
        r_pending  = sys_r;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        m_req = '0;
        repeat (5) cycle();
    endtask

    task automatic random_masters();
        bit mine;
        for (int k = 0; k < N; k++) begin
            mine = (mp_phase != 0) && (mp_m == k);
            if (mine && mp_phase == 3) begin
                m_req[k] = 1'b0;
            end else if (mine) begin
                // Fields were latched at grant; disturbing them must not matter.
                if ($urandom_range(0, 2) == 0) begin
                    m_we[k]    = 1'($urandom_range(0, 1));
                    b_addr[k]  = $urandom;
                    b_wdata[k] = $urandom;
                end
            end else if (!m_req[k]) begin
                if ($urandom_range(0, 2) == 0) begin
                    m_req[k]   = 1'b1;
                    m_we[k]    = 1'($urandom_range(0, 1));
                    b_addr[k]  = $urandom;
                    b_wdata[k] = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                m_req[k] = 1'b0;
            end
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        int            m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rline;
        logic [DW-1:0] exp_line;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t vecs [5];

    int            lat, strobes, s_w, s_r, got_first;
    logic          done_seen;
    logic [AW-1:0] s_waddr, s_raddr;
    logic [DW-1:0] s_line, got_rdata;
    logic [N-1:0]  prev;
    int            order [$];
    int            times [$];
    int            w3, d3, g2;

    initial begin
        vecs[0] = '{m:1, we:1'b1, addr:32'h10,        wdata:32'hA5A5_0001, rline:32'h0,         exp_line:32'hA5A5_0001, exp_rdata:32'h0,         exp_lat:4};
        vecs[1] = '{m:0, we:1'b0, addr:32'h11,        wdata:32'h5555_5555, rline:32'hDEAD_BEEF, exp_line:32'h0,         exp_rdata:32'hDEAD_BEEF, exp_lat:4};
        vecs[2] = '{m:3, we:1'b1, addr:32'h7FFC,      wdata:32'hFFFF_FFFF, rline:32'h1111_1111, exp_line:32'hFFFF_FFFF, exp_rdata:32'hDEAD_BEEF, exp_lat:4};
        vecs[3] = '{m:2, we:1'b0, addr:32'hFFFF_FFFF, wdata:32'h0,         rline:32'h0,         exp_line:32'h0,         exp_rdata:32'h0,         exp_lat:4};
        vecs[4] = '{m:1, we:1'b0, addr:32'h0,         wdata:32'hCAFE_F00D, rline:32'h1234_5678, exp_line:32'h0,         exp_rdata:32'h1234_5678, exp_lat:4};

        m_req = '0;
        m_we  = '0;
        for (int k = 0; k < N; k++) begin
            b_addr[k]  = '0;
            b_wdata[k] = '0;
        end
        sys_r_line = '0;

        // Reset state.
        reset_dut();

        // Single transactions from the table.
        foreach (vecs[i]) begin
            m_we[vecs[i].m]    = vecs[i].we;
            b_addr[vecs[i].m]  = vecs[i].addr;
            b_wdata[vecs[i].m] = vecs[i].wdata;
            periph_val         = vecs[i].rline;
            m_req[vecs[i].m]   = 1'b1;
            lat = 1; strobes = 0; s_w = 0; s_r = 0; done_seen = 1'b0;
            s_waddr = '0; s_raddr = '0; s_line = '0; got_rdata = '0;
            while (!done_seen && lat < 20) begin
                cycle();
                lat++;
                if (sys_w || sys_r) begin
                    strobes++;
                    s_w = int'(sys_w); s_r = int'(sys_r);
                    s_waddr = sys_w_addr; s_raddr = sys_r_addr; s_line = sys_w_line;
                end
                if (m_done[vecs[i].m]) begin
                    done_seen = 1'b1;
                    got_rdata = m_rdata;
                    m_req[vecs[i].m] = 1'b0;
                end
            end
            chk("vec_done",    64'(done_seen), 64'(1));
            chk("vec_latency", 64'(lat),       64'(vecs[i].exp_lat));
            chk("vec_strobes", 64'(strobes),   64'(1));
            chk("vec_sys_w",   64'(s_w),       64'(vecs[i].we));
            chk("vec_sys_r",   64'(s_r),       64'(!vecs[i].we));
            chk("vec_waddr",   64'(s_waddr),   64'(vecs[i].addr));
            chk("vec_raddr",   64'(s_raddr),   64'(vecs[i].addr));
            chk("vec_wline",   64'(s_line),    64'(vecs[i].exp_line));
            chk("vec_rdata",   64'(got_rdata), 64'(vecs[i].exp_rdata));
            cycle();
        end

`ifdef ARB_FIXED_PRIO0_EN
        // Masters 0 and 2 request; 0 wins until it drops after its third completion.
        m_req = '0; m_we = '0;
        b_addr[0] = 32'h100; b_addr[2] = 32'h200;
        m_req[0] = 1'b1; m_req[2] = 1'b1;
        reset_dut();
        order.delete(); prev = '0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            cycle();
            if (m_gnt != '0 && prev == '0) order.push_back(onehot_idx(m_gnt));
            prev = m_gnt;
            if (m_done[0] && order.size() == 3) m_req[0] = 1'b0;
        end
        chk("prio_count", 64'(order.size()), 64'(4));
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("prio_order", 64'(order[i]), 64'((i < 3) ? 0 : 2));
        drain();
`else
        // Contention: every master requests continuously from reset.
        m_req = '1;
        m_we  = 4'b0101;
        for (int k = 0; k < N; k++) b_addr[k] = AW'(32'h40 + k);
        reset_dut();
        order.delete(); times.delete(); prev = '0;
        for (int c = 1; c <= 26; c++) begin
            cycle();
            chk("cont_onehot", 64'($onehot0(m_gnt)), 64'(1));
            if (m_gnt != '0 && prev == '0) begin
                order.push_back(onehot_idx(m_gnt));
                times.push_back(c);
            end
            prev = m_gnt;
        end
        chk("cont_count", 64'(order.size() >= 6), 64'(1));
        for (int i = 0; i < order.size() && i < 6; i++) begin
            chk("cont_order", 64'(order[i]), 64'(i % N));
            if (i > 0) chk("cont_gap", 64'(times[i] - times[i-1]), 64'(LAT_CYCLES));
        end
        drain();
`endif

        // Withdrawal: master 2 pulses req while busy; master 3 drops req right after its grant.
        m_req = '0;
        reset_dut();
        m_we[3] = 1'b1; b_addr[3] = 32'h30; b_wdata[3] = 32'h3333_0003; m_req[3] = 1'b1;
        cycle();
        chk("wd_gnt3", 64'(m_gnt), 64'(4'b1000));
        w3 = int'(sys_w && sys_w_addr == 32'h30);
        d3 = 0; g2 = 0;
        m_req[3] = 1'b0;
        m_we[2] = 1'b0; b_addr[2] = 32'h20; m_req[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (i == 0) m_req[2] = 1'b0;
            if (sys_w) w3++;
            if (m_done[3]) d3++;
            if (m_gnt[2]) g2++;
        end
        chk("wd_strobe3", 64'(w3), 64'(1));
        chk("wd_done3",   64'(d3), 64'(1));
        chk("wd_gnt2",    64'(g2), 64'(0));

        // Reset during the strobe cycle of a read; pointer must restart so master 0 wins again.
        m_req = '0;
        reset_dut();
        m_we[0] = 1'b0; b_addr[0] = 32'h11;
        m_we[1] = 1'b0; b_addr[1] = 32'h44;
        m_req[0] = 1'b1; m_req[1] = 1'b1;
        cycle();
        chk("rm_issue", 64'(sys_r), 64'(1));
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rm_gnt_zero",  64'(m_gnt),  64'(0));
        chk("rm_done_zero", 64'(m_done), 64'(0));
        cycle();
        rst = 1'b0;
        got_first = 0;
        for (int i = 0; i < 10 && got_first == 0; i++) begin
            cycle();
            if (m_gnt != '0) got_first = int'(m_gnt);
        end
        chk("rm_first_gnt", 64'(got_first), 64'(4'b0001));
        drain();

        // Random legal traffic with occasional resets.
        reset_dut();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            periph_val = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
            random_masters();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral bus (sys_w_addr/sys_r_addr/sys_w_line/sys_r_line/sys_w/sys_r) among N_MASTERS requesters, e.g. CPU core and DMA.
- Sequences each access as one bus strobe cycle, then one response cycle. This matches peripherals such as the pin-mux control register, which act on the posedge ending the strobe cycle and drive sys_r_line only for the cycle after it.
- Round-robin arbitration. One transaction in flight at a time.

Parameters:
- N_MASTERS, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m_req  in  N_MASTERS  per-master request level
- m_we  in  N_MASTERS  per-master 1=write, 0=read
- m_addr  in  N_MASTERS*AW  packed addresses; master k uses bits [k*AW+AW-1:k*AW]
- m_wdata  in  N_MASTERS*DW  packed write data, same packing as m_addr
- m_gnt  out  N_MASTERS  one-hot; high for the granted master's whole transaction
- m_done  out  N_MASTERS  one-cycle completion pulse to the granted master
- m_rdata  out  DW  read data, shared by all masters; valid when m_done is high for a read
- sys_w_addr  out  AW  bus write address
- sys_r_addr  out  AW  bus read address
- sys_w_line  out  DW  bus write data
- sys_r_line  in  DW  bus read data, returned by peripherals
- sys_w  out  1  write strobe
- sys_r  out  1  read strobe

Behaviour:
- Reset (async) values:
  - state=IDLE; m_gnt=0, m_done=0, m_rdata=0.
  - sys_w=0, sys_r=0; sys_w_addr=sys_r_addr=sys_w_line=0.
  - rr pointer=N_MASTERS-1, so master 0 wins first.
- All outputs are registered.
- FSM states: IDLE -> ISSUE -> RESP -> DONE -> IDLE.
- IDLE:
  - If m_req is nonzero, pick the winner. Search starts at pointer+1 and wraps modulo N_MASTERS; the first master with req=1 wins.
  - Latch the winner index, we, addr and wdata. Set m_gnt[winner]=1. Update pointer=winner. Go to ISSUE.
  - With no request, stay in IDLE with the bus idle (all outputs 0).
- ISSUE (exactly 1 cycle):
  - sys_w=we and sys_r=~we.
  - sys_w_addr=sys_r_addr=latched addr.
  - sys_w_line = latched wdata for a write, 0 for a read.
- RESP (1 cycle):
  - Strobes 0; addresses and data return to 0.
  - For a read, sys_r_line is sampled at the posedge ending RESP and registered into m_rdata.
  - For a write, m_rdata is unchanged.
- DONE (1 cycle):
  - m_done[winner]=1.
  - At the end of DONE: m_gnt=0, m_done=0, go to IDLE.
- Latency:
  - req to done pulse: 4 cycles, fixed for reads and writes.
  - Back-to-back throughput: 1 transaction per 4 cycles.
- Master obligations:
  - Hold addr, we and wdata from req until m_gnt. Values are latched at grant, so later changes are ignored.
  - Drop req in the cycle m_done is seen. A req still high in IDLE is a new transaction.
- Request withdrawal:
  - Dropping req before the grant means no transaction occurs.
  - Dropping req after the grant is ignored; the transaction completes.
- Simultaneous requests: resolved by round-robin. No master waits more than N_MASTERS-1 transactions.
- Unclaimed reads: m_rdata takes whatever sys_r_line carries. Decode errors are not detected.
- Reset mid-transaction: abort immediately with all outputs at reset values. No m_done is issued; the master reissues.

Optional Feature:
- Macro ARB_FIXED_PRIO0_EN.
- Defined: master 0 wins any IDLE arbitration in which m_req[0]=1. The remaining masters rotate round-robin among themselves, and the pointer is not updated on master-0 grants.
- Undefined: pure round-robin for all masters.

Decomposition:
- Package periph_bus_pkg holds:
  - AW/DW defaults;
  - FSM state encoding (IDLE=0, ISSUE=1, RESP=2, DONE=3);
  - localparam LAT_CYCLES=4.
- Sub-module rr_arbiter: combinational round-robin select over a req vector.
  - Inputs: req, pointer.
  - Outputs: one-hot grant, index, any.
  - The FSM and the bus drive stay in the top module.

Test Plan:
- Single write: master 1 writes addr 0x10, data 0xA5A5_0001.
  - sys_w=1 for exactly one cycle with sys_w_addr=0x10 and sys_w_line=0xA5A5_0001.
  - m_done[1] arrives 4 cycles after req.
- Single read: master 0 reads 0x11; the bench model drives 0xDEAD_BEEF in the cycle after sys_r.
  - m_rdata=0xDEAD_BEEF while m_done[0]=1.
- Contention: all 4 masters hold req continuously from reset.
  - Grant order is 0,1,2,3,0,1.
  - Each grant is 4 cycles apart and m_gnt is one-hot throughout.
- Withdrawal: master 2 raises and drops req before IDLE samples it; master 3 drops req one cycle after its grant.
  - Master 2 gets no transaction.
  - Master 3's strobe is still issued and m_done[3] still pulses.
- Reset mid-op: assert rst during ISSUE of a read.
  - All outputs are 0 immediately, with no m_done.
  - After rst falls, a pending req from master 0 is granted first.
- ARB_FIXED_PRIO0_EN: masters 0 and 2 request continuously.
  - Master 0 wins every arbitration.
  - When master 0 drops req, master 2 is granted next.
